fir_channel_scheduler: RTL and testbench
========================================

# fir_channel_scheduler

Sequences and shares one time-multiplexed 80-tap FIR datapath (4 taps per compute cycle) between two independent 8-bit sample channels. Each channel hands samples in through a valid/ready handshake into a one-entry holding register. A round-robin arbiter grants the datapath to one channel at a time and drives its start/enable timing. Each finished result is returned on a single output port, tagged with the channel it belongs to.

## Interface
- `TAPS`, 80, FIR length; must be an integer multiple of `TAPS_PER_CYCLE`
- `TAPS_PER_CYCLE`, 4, taps the datapath evaluates per enabled cycle
- `DATA_W`, 8, sample and result width (signed two's complement)
- `clk` in 1: single clock; all logic on rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `ch0_data` in DATA_W: channel 0 sample
- `ch0_valid` in 1: channel 0 sample valid
- `ch0_ready` out 1: channel 0 holding register empty
- `ch1_data`, `ch1_valid`, `ch1_ready`: same as channel 0, for channel 1
- `dp_sample` out DATA_W: sample presented to the datapath
- `dp_start` out 1: one-cycle pulse; datapath shifts `dp_sample` into its delay line
- `dp_en` out 1: datapath accumulate enable; high for exactly RUN = TAPS/TAPS_PER_CYCLE consecutive cycles per job
- `dp_result` in DATA_W: datapath output; stable while `dp_en`=0 after a run
- `out_data` out DATA_W: result
- `out_ch` out 1: channel that produced `out_data`
- `out_valid` out 1: result valid
- `out_ready` in 1: consumer accepts the result

## Operation
- **Holding registers.** One per channel, each with a `full` flag.
  - `chN_ready` = !full_N (combinational).
  - The register captures `chN_data` on the edge where `chN_valid && chN_ready`.
- **FSM states.** IDLE, LOAD, RUN, DONE.
  - **IDLE:** if neither register is full, stay. Otherwise grant a channel and go to LOAD.
    - If only one register is full, grant that channel.
    - If both are full, grant the channel selected by the round-robin pointer `rr`.
    - After any grant, `rr` ← the other channel.
  - **LOAD:** one cycle.
    - `dp_sample` = granted holding register; `dp_start`=1.
    - At the end of the cycle: clear that register's `full`, set `cnt`←0, go to RUN.
  - **RUN:** `dp_en`=1, `cnt` increments each cycle. When `cnt`==RUN-1, go to DONE.
  - **DONE:** `dp_en`=0.
    - If `!out_valid || out_ready`: load `out_data`←`dp_result`, `out_ch`←granted channel, `out_valid`←1, go to IDLE.
    - Otherwise stay in DONE (backpressure; the datapath holds its result).
- **Output register.** `out_valid` clears on the edge where `out_valid && out_ready`, unless DONE reloads it in the same edge. In that case it stays 1 with the new data.
- **Ordering.** Per-channel sample order is preserved. Channels interleave strictly when both are continuously full.
- **Data path widths.** `dp_result` passes through unmodified: no rounding or saturation in this block. `cnt` width is clog2(RUN).
- **Concurrent events.** A channel whose register is freed in LOAD may accept a new sample in the very next cycle, while its previous sample is still in RUN.

## Timing
- **Reset.** While `rst_n`=0:
  - state=IDLE; `rr`=ch0; `cnt`=0; both `full`=0.
  - `chN_ready`=1; `dp_sample`=0; `dp_start`=0; `dp_en`=0.
  - `out_data`=0; `out_ch`=0; `out_valid`=0.
- **Reset mid-operation.** A job in progress is aborted. Held samples and any in-flight result are discarded, and `dp_en`/`dp_start` drop immediately (asynchronous reset).
- **Latency (no backpressure).** Taking the accept edge as E0:
  - LOAD occupies the cycle after E1.
  - RUN occupies the cycles between edges E2 and E22.
  - DONE is the cycle after E22.
  - `out_valid` is high after E23.
  - Total: 23 cycles from accept to valid output.
- **Throughput.** One job every RUN+3 = 23 cycles per shared datapath, with both channels combined.
- **Handshake rules.**
  - `chN_valid` and `chN_data` must stay stable until accepted.
  - `out_data` and `out_ch` stay stable while `out_valid && !out_ready`.
- **`dp_start` and `dp_en`** are never high together. `dp_en` is high for exactly RUN cycles per LOAD.

## Test plan
- **Single sample, latency:** reset, ch0 sends 0x10, `out_ready`=1, datapath model returns 0x05 → `out_valid` high 23 cycles after accept, `out_data`=0x05, `out_ch`=0; `dp_en` high for exactly 20 cycles.
- **Round robin:** both channels present samples on the same cycle → ch0 is served first (`rr` reset value), then ch1. With both held continuously full, outputs alternate 0,1,0,1 and no channel is served twice in a row.
- **Backpressure:** `out_ready`=0 while the first result is pending → a second job stalls in DONE with `dp_en`=0. Raising `out_ready` yields both results in order with no loss or duplication.
- **Holding-register boundary:** ch1 presents 3 back-to-back samples → `ch1_ready` drops after the first accept and rises in the cycle after that job's LOAD. All 3 outputs appear tagged `out_ch`=1, in order.
- **Reset mid-RUN:** assert `rst_n`=0 at RUN cycle 10 → `dp_en`=0 immediately, `out_valid`=0, both `chN_ready`=1. No result is produced for the aborted sample after reset release.
- **Concurrent output:** `out_valid && out_ready` on the same edge DONE reloads → `out_valid` stays 1 and `out_data` updates to the new result.

Source files
------------

// File: rtl/fir_channel_scheduler.sv
// Two-channel front end for one shared, time-multiplexed FIR datapath.
// Round-robin arbitration, datapath start/enable sequencing, tagged result output.
module fir_channel_scheduler #(
  parameter int unsigned TAPS           = 80,
  parameter int unsigned TAPS_PER_CYCLE = 4,
  parameter int unsigned DATA_W         = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] ch0_data,
  input  logic              ch0_valid,
  output logic              ch0_ready,
  input  logic [DATA_W-1:0] ch1_data,
  input  logic              ch1_valid,
  output logic              ch1_ready,
  output logic [DATA_W-1:0] dp_sample,
  output logic              dp_start,
  output logic              dp_en,
  input  logic [DATA_W-1:0] dp_result,
  output logic [DATA_W-1:0] out_data,
  output logic              out_ch,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned RUN_LEN = TAPS / TAPS_PER_CYCLE;
  localparam int unsigned CNT_W   = (RUN_LEN > 1) ? $clog2(RUN_LEN) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_e;

  state_e             state_q;
  logic               rr_q;
  logic               gnt_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               full0_q, full1_q;
  logic [DATA_W-1:0]  hold0_q, hold1_q;
  logic [DATA_W-1:0]  dp_sample_q;
  logic               dp_start_q, dp_en_q;
  logic [DATA_W-1:0]  out_data_q;
  logic               out_ch_q, out_valid_q;
  logic               gnt_d;

  assign ch0_ready = !full0_q;
  assign ch1_ready = !full1_q;
  assign dp_sample = dp_sample_q;
  assign dp_start  = dp_start_q;
  assign dp_en     = dp_en_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

  // Sole full channel wins; round-robin pointer breaks a tie.
  assign gnt_d = (full0_q && full1_q) ? rr_q : full1_q;

  // Holding registers: fill on handshake, free at the end of the granted LOAD cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full0_q <= 1'b0;
      full1_q <= 1'b0;
      hold0_q <= '0;
      hold1_q <= '0;
    end else begin
      if (ch0_valid && !full0_q) begin
        hold0_q <= ch0_data;
        full0_q <= 1'b1;
      end else if (state_q == S_LOAD && !gnt_q) begin
        full0_q <= 1'b0;
      end
      if (ch1_valid && !full1_q) begin
        hold1_q <= ch1_data;
        full1_q <= 1'b1;
      end else if (state_q == S_LOAD && gnt_q) begin
        full1_q <= 1'b0;
      end
    end
  end

  // Job sequencer with registered datapath controls and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_q        <= 1'b0;
      gnt_q       <= 1'b0;
      cnt_q       <= '0;
      dp_sample_q <= '0;
      dp_start_q  <= 1'b0;
      dp_en_q     <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (full0_q || full1_q) begin
            gnt_q       <= gnt_d;
            rr_q        <= !gnt_d;
            dp_sample_q <= gnt_d ? hold1_q : hold0_q;
            dp_start_q  <= 1'b1;
            state_q     <= S_LOAD;
          end
        end
        S_LOAD: begin
          dp_start_q <= 1'b0;
          dp_en_q    <= 1'b1;
          cnt_q      <= '0;
          state_q    <= S_RUN;
        end
        S_RUN: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(RUN_LEN - 1)) begin
            dp_en_q <= 1'b0;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          // Wait for the output register to free; a same-edge pop and reload keeps valid high.
          if (!out_valid_q || out_ready) begin
            out_data_q  <= dp_result;
            out_ch_q    <= gnt_q;
            out_valid_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Scoreboard bench for fir_channel_scheduler with a behavioural datapath model
// (result = sample - 0x0B, valid only after exactly 20 enable cycles).
module tb_fir_channel_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ch0_data = '0, ch1_data = '0;
  logic       ch0_valid = 1'b0, ch1_valid = 1'b0;
  logic       ch0_ready, ch1_ready;
  logic [7:0] dp_sample;
  logic       dp_start, dp_en;
  logic [7:0] dp_result;
  logic [7:0] out_data;
  logic       out_ch, out_valid;
  logic       out_ready = 1'b0;

  typedef struct packed {
    logic       ch;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   en_cycles = 0;
  logic [7:0] m_smp;
  int   m_cnt;

  fir_channel_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .ch0_data(ch0_data), .ch0_valid(ch0_valid), .ch0_ready(ch0_ready),
    .ch1_data(ch1_data), .ch1_valid(ch1_valid), .ch1_ready(ch1_ready),
    .dp_sample(dp_sample), .dp_start(dp_start), .dp_en(dp_en),
    .dp_result(dp_result),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial forever #5 clk = ~clk;

  // Datapath model: garbage (0xEE) unless the run had exactly 20 enable cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_result <= 8'hEE;
      m_smp     <= 8'h00;
      m_cnt     <= 0;
    end else if (dp_start) begin
      m_smp     <= dp_sample;
      m_cnt     <= 0;
      dp_result <= 8'hEE;
    end else if (dp_en) begin
      m_cnt     <= m_cnt + 1;
      dp_result <= (m_cnt == 19) ? m_smp - 8'h0B : 8'hEE;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_out(input logic ch, input logic [7:0] d);
    exp_t e;
    e.ch   = ch;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (dp_en) en_cycles++;
        chk("start_en_exclusive", int'(dp_start && dp_en), 0);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", int'(out_data), -1);
          end else begin
            e = exp_q.pop_front();
            chk("out_ch", int'(out_ch), int'(e.ch));
            chk("out_data", int'(out_data), int'(e.data));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    ch0_valid = 1'b0;
    ch1_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic send(input bit ch, input logic [7:0] d);
    bit rdy;
    int n;
    n = 0;
    if (ch) begin ch1_data = d; ch1_valid = 1'b1; end
    else    begin ch0_data = d; ch0_valid = 1'b1; end
    do begin
      rdy = ch ? ch1_ready : ch0_ready;
      tick();
      n++;
    end while (!rdy && n < 300);
    if (!rdy) chk("send_timeout", 0, 1);
    if (ch) ch1_valid = 1'b0;
    else    ch0_valid = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      tick();
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    int lat;
    // Reset values.
    #12;
    chk("rst_ch0_ready", int'(ch0_ready), 1);
    chk("rst_ch1_ready", int'(ch1_ready), 1);
    chk("rst_dp_en", int'(dp_en), 0);
    chk("rst_dp_start", int'(dp_start), 0);
    chk("rst_dp_sample", int'(dp_sample), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    do_reset();

    // Single sample latency.
    out_ready = 1'b1;
    en_cycles = 0;
    expect_out(1'b0, 8'h05);
    ch0_data  = 8'h10;
    ch0_valid = 1'b1;
    tick();
    ch0_valid = 1'b0;
    chk("ch0_ready_after_accept", int'(ch0_ready), 0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk("latency", lat, 23);
    chk("dp_en_cycles", en_cycles, 20);
    drain(10);

    // Round robin with both channels kept full.
    do_reset();
    out_ready = 1'b1;
    expect_out(1'b0, 8'h15);
    expect_out(1'b1, 8'h25);
    expect_out(1'b0, 8'h16);
    expect_out(1'b1, 8'h26);
    expect_out(1'b0, 8'h17);
    expect_out(1'b1, 8'h27);
    fork
      begin send(1'b0, 8'h20); send(1'b0, 8'h21); send(1'b0, 8'h22); end
      begin send(1'b1, 8'h30); send(1'b1, 8'h31); send(1'b1, 8'h32); end
    join
    drain(400);

    // Backpressure, then same-edge pop and reload.
    out_ready = 1'b0;
    expect_out(1'b0, 8'h35);
    expect_out(1'b0, 8'h36);
    send(1'b0, 8'h40);
    send(1'b0, 8'h41);
    repeat (80) tick();
    chk("bp_dp_en", int'(dp_en), 0);
    chk("bp_dp_start", int'(dp_start), 0);
    chk("bp_out_valid", int'(out_valid), 1);
    chk("bp_out_data", int'(out_data), 8'h35);
    chk("bp_ch0_ready", int'(ch0_ready), 1);
    out_ready = 1'b1;
    tick();
    chk("reload_out_valid", int'(out_valid), 1);
    chk("reload_out_data", int'(out_data), 8'h36);
    tick();
    chk("reload_valid_clears", int'(out_valid), 0);
    drain(10);

    // Holding-register boundary on ch1.
    expect_out(1'b1, 8'h45);
    expect_out(1'b1, 8'h46);
    expect_out(1'b1, 8'h47);
    ch1_data  = 8'h50;
    ch1_valid = 1'b1;
    tick();
    ch1_valid = 1'b0;
    chk("ch1_ready_e0", int'(ch1_ready), 0);
    tick();
    chk("ch1_ready_load", int'(ch1_ready), 0);
    tick();
    chk("ch1_ready_after_load", int'(ch1_ready), 1);
    send(1'b1, 8'h51);
    send(1'b1, 8'h52);
    drain(200);

    // Reset in RUN cycle 10 with a second sample held.
    send(1'b0, 8'h60);
    send(1'b1, 8'h70);
    lat = 0;
    while (!dp_en && lat < 20) begin
      tick();
      lat++;
    end
    chk("mid_run_reached", int'(dp_en), 1);
    repeat (9) tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_dp_en", int'(dp_en), 0);
    chk("mrst_dp_start", int'(dp_start), 0);
    chk("mrst_out_valid", int'(out_valid), 0);
    chk("mrst_ch0_ready", int'(ch0_ready), 1);
    chk("mrst_ch1_ready", int'(ch1_ready), 1);
    repeat (2) tick();
    rst_n = 1'b1;
    en_cycles = 0;
    repeat (60) tick();
    chk("post_rst_no_job", en_cycles, 0);
    chk("post_rst_out_valid", int'(out_valid), 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
